// File: rtl/bus_pkg.sv
// Shared bus widths, arbiter state encoding and the default error read pattern
// used by the system bus hub and its host-side arbiters.
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_MW = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [BUS_DW-1:0] BUS_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requesting index strictly
// after 'last', wrapping modulo NUM_REQ, plus a flag saying whether anyone requested.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      pick_idx,
    output logic               pick_valid
);

    logic [IW-1:0] cand_s;

    // Scan from the farthest offset down so the nearest requester after 'last' wins.
    always_comb begin
        pick_idx   = last;
        pick_valid = 1'b0;
        cand_s     = {IW{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s     = IW'((int'(last) + k) % NUM_REQ);
            pick_idx   = req[cand_s] ? cand_s : pick_idx;
            pick_valid = pick_valid | req[cand_s];
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing the bus hub host port among NUM_HOSTS masters,
// one transaction in flight, with a per-transaction timeout.
module bus_host_arbiter
    import bus_pkg::*;
#(
    parameter int                 NUM_HOSTS      = 2,
    parameter int                 TIMEOUT_CYCLES = 255,
    parameter logic [BUS_DW-1:0]  ERR_RDATA      = BUS_ERR_RDATA,
    localparam int                GW             = $clog2(NUM_HOSTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BUS_AW*NUM_HOSTS-1:0]   req_address,
    input  logic [BUS_DW*NUM_HOSTS-1:0]   req_data_write,
    input  logic [BUS_MW*NUM_HOSTS-1:0]   req_write_mask,
    input  logic [NUM_HOSTS-1:0]          req_wen,
    input  logic [NUM_HOSTS-1:0]          req_ren,
    output logic [BUS_DW-1:0]             req_data_read,
    output logic [NUM_HOSTS-1:0]          req_ready,
    output logic [NUM_HOSTS-1:0]          req_error,
    output logic [BUS_AW-1:0]             dev_address,
    output logic [BUS_DW-1:0]             dev_data_write,
    output logic [BUS_MW-1:0]             dev_write_mask,
    output logic                          dev_wen,
    output logic                          dev_ren,
    input  logic [BUS_DW-1:0]             dev_data_read,
    input  logic                          dev_ready,
    output logic [GW-1:0]                 grant_idx
);

    localparam int             CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  TMO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic           TMO_EN    = (TIMEOUT_CYCLES != 0);

    arb_state_t             state_r;
    arb_state_t             state_next_s;
    logic [GW-1:0]          grant_r;
    logic [GW-1:0]          last_r;
    logic [CW-1:0]          tcnt_r;
    logic [GW-1:0]          pick_idx_s;
    logic                   pick_valid_s;
    logic [NUM_HOSTS-1:0]   req_any_s;
    logic                   busy_s;
    logic                   g_wen_s;
    logic                   g_ren_s;
    logic                   tmo_hit_s;
    logic                   done_s;

    assign req_any_s = req_wen | req_ren;
    assign busy_s    = (state_r == ARB_BUSY);
    // A request with both enables set is a write.
    assign g_wen_s   = req_wen[grant_r];
    assign g_ren_s   = req_ren[grant_r] & ~g_wen_s;
    // tcnt_r holds the 1-based BUSY cycle number; dev_ready beats a coincident timeout.
    assign tmo_hit_s = busy_s & TMO_EN & ~dev_ready & (tcnt_r >= TMO_LIMIT);
    assign done_s    = busy_s & (dev_ready | tmo_hit_s);
    assign grant_idx = grant_r;

    rr_pick #(
        .NUM_REQ (NUM_HOSTS),
        .IW      (GW)
    ) u_rr_pick (
        .req        (req_any_s),
        .last       (last_r),
        .pick_idx   (pick_idx_s),
        .pick_valid (pick_valid_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant, round-robin pointer and timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r <= {GW{1'b0}};
            last_r  <= GW'(NUM_HOSTS - 1);
            tcnt_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        grant_r <= pick_idx_s;
                        tcnt_r  <= CW'(1);
                    end
                end
                ARB_BUSY: begin
                    if (done_s) begin
                        last_r <= grant_r;
                        tcnt_r <= {CW{1'b0}};
                    end else if (tcnt_r != {CW{1'b1}}) begin
                        tcnt_r <= tcnt_r + CW'(1);
                    end
                end
                default: begin
                    tcnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Next-state logic; the forced return to IDLE provides the gap cycle that
    // swallows the hub's trailing duplicate ready.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARB_IDLE: state_next_s = pick_valid_s ? ARB_BUSY : ARB_IDLE;
            ARB_BUSY: state_next_s = done_s ? ARB_IDLE : ARB_BUSY;
            default:  state_next_s = ARB_IDLE;
        endcase
    end

    // Outputs: mirror the granted host while BUSY, everything quiet in IDLE.
    always_comb begin
        dev_address    = {BUS_AW{1'b0}};
        dev_data_write = {BUS_DW{1'b0}};
        dev_write_mask = {BUS_MW{1'b0}};
        dev_wen        = 1'b0;
        dev_ren        = 1'b0;
        req_ready      = {NUM_HOSTS{1'b0}};
        req_error      = {NUM_HOSTS{1'b0}};
        req_data_read  = {BUS_DW{1'b0}};
        if (busy_s) begin
            dev_address    = req_address[{grant_r, 5'b00000} +: BUS_AW];
            dev_data_write = req_data_write[{grant_r, 5'b00000} +: BUS_DW];
            dev_write_mask = req_write_mask[{grant_r, 2'b00} +: BUS_MW];
            dev_wen        = g_wen_s & ~tmo_hit_s;
            dev_ren        = g_ren_s & ~tmo_hit_s;
            if (dev_ready) begin
                req_ready[grant_r] = 1'b1;
                req_data_read      = dev_data_read;
            end else if (tmo_hit_s) begin
                req_ready[grant_r] = 1'b1;
                req_error[grant_r] = 1'b1;
                req_data_read      = ERR_RDATA;
            end else begin
                req_data_read      = {BUS_DW{1'b0}};
            end
        end else begin
            dev_wen = 1'b0;
            dev_ren = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Randomized bench for bus_host_arbiter: random masters and a random device,
// every cycle compared against a transaction-level reference model.
module tb_bus_host_arbiter;

    localparam int          NH  = 3;
    localparam int          TMO = 4;
    localparam int          IW  = $clog2(NH);
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*NH-1:0]  req_address;
    logic [32*NH-1:0]  req_data_write;
    logic [4*NH-1:0]   req_write_mask;
    logic [NH-1:0]     req_wen;
    logic [NH-1:0]     req_ren;
    logic [31:0]       req_data_read;
    logic [NH-1:0]     req_ready;
    logic [NH-1:0]     req_error;
    logic [31:0]       dev_address;
    logic [31:0]       dev_data_write;
    logic [3:0]        dev_write_mask;
    logic              dev_wen;
    logic              dev_ren;
    logic [31:0]       dev_data_read;
    logic              dev_ready;
    logic [IW-1:0]     grant_idx;

    bus_host_arbiter #(
        .NUM_HOSTS      (NH),
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_address    (req_address),
        .req_data_write (req_data_write),
        .req_write_mask (req_write_mask),
        .req_wen        (req_wen),
        .req_ren        (req_ren),
        .req_data_read  (req_data_read),
        .req_ready      (req_ready),
        .req_error      (req_error),
        .dev_address    (dev_address),
        .dev_data_write (dev_data_write),
        .dev_write_mask (dev_write_mask),
        .dev_wen        (dev_wen),
        .dev_ren        (dev_ren),
        .dev_data_read  (dev_data_read),
        .dev_ready      (dev_ready),
        .grant_idx      (grant_idx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Master side state
    bit          h_act [NH];
    logic [31:0] h_addr[NH];
    logic [31:0] h_data[NH];
    logic [3:0]  h_mask[NH];
    bit          h_wen [NH];
    bit          h_ren [NH];

    // Reference model state: owner of the bus, BUSY cycle number, round-robin pointer
    bit m_busy;
    int m_owner, m_cnt, m_last, m_grant;
    bit m_ready_prev[NH];

    initial begin
        int start_pct, rdy_pct, sel, h, p;
        bit do_rst, done, tmo;
        logic [31:0]   e_addr, e_wd, e_rd;
        logic [3:0]    e_mask;
        logic          e_wen, e_ren;
        logic [NH-1:0] e_rdy, e_err;

        rst = 1'b0;
        req_address = '0; req_data_write = '0; req_write_mask = '0;
        req_wen = '0; req_ren = '0; dev_data_read = '0; dev_ready = 1'b0;
        m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_last = NH - 1; m_grant = 0;
        for (int i = 0; i < NH; i++) begin
            h_act[i] = 1'b0; m_ready_prev[i] = 1'b0;
            h_addr[i] = '0; h_data[i] = '0; h_mask[i] = '0; h_wen[i] = 1'b0; h_ren[i] = 1'b0;
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc < 300)       begin start_pct = 100; rdy_pct = 50;  end
            else if (cyc < 1500) begin start_pct = 30;  rdy_pct = 35;  end
            else if (cyc < 2000) begin start_pct = 50;  rdy_pct = 0;   end
            else if (cyc < 2600) begin start_pct = 40;  rdy_pct = 100; end
            else if (cyc < 2800) begin start_pct = 100; rdy_pct = 20;  end
            else                 begin start_pct = 60;  rdy_pct = 25;  end
            do_rst = (cyc < 3) || (cyc == 1000) || (cyc == 2700) ||
                     (cyc > 10 && $urandom_range(0, 249) == 0);
            rst = do_rst ? 1'b0 : 1'b1;

            // Masters: finish on ready, hold otherwise, maybe start a new transaction
            for (int i = 0; i < NH; i++) begin
                if (m_ready_prev[i] || do_rst) h_act[i] = 1'b0;
                if (!h_act[i] && int'($urandom_range(0, 99)) < start_pct) begin
                    h_act[i]  = 1'b1;
                    h_addr[i] = $urandom;
                    h_data[i] = $urandom;
                    h_mask[i] = 4'($urandom);
                    sel       = int'($urandom_range(0, 2));
                    h_wen[i]  = (sel != 0);
                    h_ren[i]  = (sel != 1);
                end
                req_address[i*32 +: 32]    = h_act[i] ? h_addr[i] : 32'h0;
                req_data_write[i*32 +: 32] = h_act[i] ? h_data[i] : 32'h0;
                req_write_mask[i*4 +: 4]   = h_act[i] ? h_mask[i] : 4'h0;
                req_wen[i]                 = h_act[i] & h_wen[i];
                req_ren[i]                 = h_act[i] & h_ren[i];
            end
            dev_ready     = (int'($urandom_range(0, 99)) < rdy_pct);
            dev_data_read = $urandom;
            #1;

            if (do_rst) begin
                m_busy = 1'b0; m_last = NH - 1; m_grant = 0; m_cnt = 0;
            end

            // Expected outputs for this cycle
            e_addr = '0; e_wd = '0; e_mask = '0; e_wen = 1'b0; e_ren = 1'b0;
            e_rd = '0; e_rdy = '0; e_err = '0; done = 1'b0; tmo = 1'b0;
            h = m_owner;
            if (m_busy) begin
                e_addr = req_address[h*32 +: 32];
                e_wd   = req_data_write[h*32 +: 32];
                e_mask = req_write_mask[h*4 +: 4];
                e_wen  = req_wen[h];
                e_ren  = req_ren[h] & ~req_wen[h];
                if (dev_ready) begin
                    done = 1'b1; e_rdy[h] = 1'b1; e_rd = dev_data_read;
                end else if (m_cnt >= TMO) begin
                    done = 1'b1; tmo = 1'b1; e_rdy[h] = 1'b1; e_err[h] = 1'b1;
                    e_rd = ERR; e_wen = 1'b0; e_ren = 1'b0;
                end
            end

            check_vec("dev_address",    64'(dev_address),    64'(e_addr));
            check_vec("dev_data_write", 64'(dev_data_write), 64'(e_wd));
            check_vec("dev_write_mask", 64'(dev_write_mask), 64'(e_mask));
            check_vec("dev_wen",        64'(dev_wen),        64'(e_wen));
            check_vec("dev_ren",        64'(dev_ren),        64'(e_ren));
            check_vec("req_ready",      64'(req_ready),      64'(e_rdy));
            check_vec("req_error",      64'(req_error),      64'(e_err));
            check_vec("grant_idx",      64'(grant_idx),      64'(m_grant));
            if (!(tmo && req_wen[h]))
                check_vec("req_data_read", 64'(req_data_read), 64'(e_rd));

            // Advance the model across the coming clock edge
            if (!do_rst) begin
                if (m_busy) begin
                    if (done) begin
                        m_busy = 1'b0;
                        m_last = m_owner;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    p = -1;
                    for (int k = 1; k <= NH; k++) begin
                        h = (m_last + k) % NH;
                        if (p < 0 && (req_wen[h] || req_ren[h])) p = h;
                    end
                    if (p >= 0) begin
                        m_busy = 1'b1; m_owner = p; m_grant = p; m_cnt = 1;
                    end
                end
            end
            for (int i = 0; i < NH; i++) m_ready_prev[i] = e_rdy[i];
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Shares the single host port of the system bus hub between NUM_HOSTS bus masters (CPU core, DMA/loader, debug).
- Round-robin, one transaction in flight, registered grant.
- Per-transaction timeout so a missing or unmapped device cannot hang a master.
- Sits between the masters and bus_hub_2's host_* port inside the SoC top.

Parameters:
NUM_HOSTS, 2, number of requesting masters (2..8)
TIMEOUT_CYCLES, 255, cycles in BUSY without dev_ready before forced completion; 0 disables timeout
ERR_RDATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
req_address  in  32*NUM_HOSTS  host i at [i*32+:32]
req_data_write  in  32*NUM_HOSTS  write data per host
req_write_mask  in  4*NUM_HOSTS  byte mask per host, [i*4+:4]
req_wen  in  NUM_HOSTS  write request per host
req_ren  in  NUM_HOSTS  read request per host
req_data_read  out  32  shared read data; valid only with that host's req_ready
req_ready  out  NUM_HOSTS  one-cycle completion pulse per host
req_error  out  NUM_HOSTS  one-cycle pulse coincident with req_ready on timeout
dev_address  out  32  to hub host_address
dev_data_write  out  32  to hub host_data_write
dev_write_mask  out  4  to hub host_write_mask
dev_wen  out  1  to hub host_wen
dev_ren  out  1  to hub host_ren
dev_data_read  in  32  from hub host_data_read
dev_ready  in  1  from hub host_ready
grant_idx  out  $clog2(NUM_HOSTS)  currently/last granted host (debug)

Behaviour:
- Reset (rst=0, async): state=IDLE, grant_idx=0, last_grant=NUM_HOSTS-1 (host 0 wins first), timeout counter=0; all outputs 0.
- Request from host i: req_ren[i]|req_wen[i]. Both set is a write (wen wins; dev_ren forced 0).
- FSM, 2 states:
  - IDLE: dev_* outputs 0; dev_ready ignored. If any request, pick first requesting index after last_grant, wrapping modulo NUM_HOSTS. Register grant_idx, go BUSY. No request: stay IDLE.
  - BUSY: dev_* combinationally mirror granted host's live req_* signals.
    - dev_ready=1: req_ready[grant]=1, req_data_read=dev_data_read same cycle; last_grant<=grant; next IDLE.
    - Counter reaches TIMEOUT_CYCLES (counts from 1 on first BUSY cycle): req_ready and req_error pulse for grant, req_data_read=ERR_RDATA (reads; don't-care for writes), dev_wen/dev_ren=0 that cycle, next IDLE.
    - dev_ready and timeout in same cycle: dev_ready wins, no error.
- Latency: request seen in cycle t -> dev_* driven from t+1 -> req_ready in the dev_ready cycle. Minimum 2 cycles against the 1-cycle-registered memory.
- Mandatory IDLE cycle between transactions absorbs the hub's trailing duplicate ready (memory re-registers ren held in the ready cycle). dev_ready outside BUSY never produces req_ready.
- Master contract: hold address/data/mask/ren/wen stable until req_ready. In the cycle after req_ready, deassert or present a new request; a still-asserted request there is treated as new.
- Fairness: with all hosts requesting continuously, grants rotate strictly 0,1,..,N-1,0. A lone requester is granted back-to-back (every 2 cycles + device latency).
- Granted host dropping its request in BUSY (protocol violation): dev_* follow it low; FSM waits for dev_ready/timeout normally.
- req_ready, req_error and req_data_read are 0 to non-granted hosts and in IDLE.
- Reset mid-transaction: abort immediately, no ready/error delivered, priority back to host 0.
- Counter width $clog2(TIMEOUT_CYCLES+1); saturates; cleared on entering BUSY.

Decomposition:
- Shared package bus_pkg: BUS_AW=32, BUS_DW=32, BUS_MW=4, arb_state_t enum {ARB_IDLE, ARB_BUSY}, ERR_RDATA default constant.
- One sub-module: rr_pick (combinational: request vector + last_grant -> next index + valid), reusable by future arbiters.

Test Plan:
- Host 0 read 0x10, mem responds after 1 cycle -> dev_ren high 1 cycle after request, req_ready[0] pulse with rdata, req_ready[1]=0.
- Hosts 0 and 1 both hold reads from reset -> grant order 0,1,0,1; IDLE cycle between each; no spurious req_ready.
- Host 1 write 0x20, mask 4'b0011, data 0xA5A5_1234 -> dev_wen=1, dev_write_mask=0011, dev_ren=0; req_ready[1] pulse, no error.
- TIMEOUT_CYCLES=4, dev_ready tied 0, host 0 read -> req_ready[0] and req_error[0] in 4th BUSY cycle, rdata=0xDEADBEEF, then IDLE.
- rst low in 2nd BUSY cycle of host 1 transaction -> outputs 0 immediately, no ready; after release with both requesting, host 0 granted first.
- dev_ready forced in IDLE plus duplicate ready right after completion -> no req_ready generated.
